// File: rtl/accel_pkg.sv
// Shared constants and state encodings for the accelerometer stream controller.
// The TX_CSUM state only exists when ACCEL_STREAM_CHECKSUM_EN is defined.
package accel_pkg;

  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;

  localparam logic [7:0] INIT_DATA_FORMAT = 8'h01;
  localparam logic [7:0] INIT_POWER_CTL   = 8'h08;

  typedef enum logic [2:0] {
    StInitFmt,
    StInitPwr,
    StIdle,
    StRead,
    StPublish,
    StTxSep,
    StTxData
`ifdef ACCEL_STREAM_CHECKSUM_EN
    , StTxCsum
`endif
  } state_e;

  typedef enum logic [1:0] {
    HsIdle,
    HsReq,
    HsWait
  } hs_state_e;

endpackage

// File: rtl/byte_req_hs.sv
// Generic req/busy handshake: req held until busy seen, completion on the first
// busy-low cycle afterwards, timeout if busy never rises within TIMEOUT cycles.
module byte_req_hs
  import accel_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_busy,
  output logic o_req,
  output logic o_idle,
  output logic o_done,
  output logic o_timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  hs_state_e       r_state, w_state_next;
  logic [CW-1:0]   r_cnt, w_cnt_next;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    o_done       = 1'b0;
    o_timeout    = 1'b0;
    unique case (r_state)
      HsIdle: begin
        if (i_start) begin
          w_state_next = HsReq;
          w_cnt_next   = '0;
        end
      end
      HsReq: begin
        if (i_busy) begin
          w_state_next = HsWait;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          o_timeout    = 1'b1;
          w_state_next = HsIdle;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      HsWait: begin
        if (!i_busy) begin
          o_done       = 1'b1;
          w_state_next = HsIdle;
        end
      end
      default: w_state_next = HsIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HsIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // req is a pure state decode, so it drops the cycle after busy is sampled high
  assign o_req  = (r_state == HsReq);
  assign o_idle = (r_state == HsIdle);

endmodule

// File: rtl/accel_stream_ctrl.sv
// Accelerometer init/sample/stream controller over SPI and UART byte engines.
// Define ACCEL_STREAM_CHECKSUM_EN to append an XOR checksum byte to each frame.
module accel_stream_ctrl
  import accel_pkg::*;
#(
  parameter int unsigned NUM_AXES      = 3,
  parameter int unsigned SAMPLE_PERIOD = 262144,
  parameter logic [7:0]  UART_SEP      = 8'h0A,
  parameter int unsigned BUSY_TIMEOUT  = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    spi_req,
  output logic                    spi_rw,
  output logic [5:0]              spi_addr,
  output logic [7:0]              spi_wdata,
  input  logic                    spi_busy,
  input  logic [7:0]              spi_rdata,
  output logic                    uart_req,
  output logic [7:0]              uart_data,
  input  logic                    uart_busy,
  output logic                    sample_valid,
  output logic [16*NUM_AXES-1:0]  sample_data,
  output logic                    init_done,
  output logic                    timeout_err
);

  localparam int unsigned NBYTES = 2 * NUM_AXES;
  localparam int unsigned SW     = 16 * NUM_AXES;

  state_e          r_state, w_state_next;
  logic [2:0]      r_idx, w_idx_next;
  logic [31:0]     r_cnt;
  logic [SW-1:0]   r_buf, w_buf_next;
  logic [SW-1:0]   r_sample;
  logic            r_init_done;
  logic            r_timeout_err;
  logic            r_spi_rw;
  logic [5:0]      r_spi_addr;
  logic [7:0]      r_spi_wdata;
  logic [7:0]      r_uart_data;
`ifdef ACCEL_STREAM_CHECKSUM_EN
  logic [7:0]      r_csum;
`endif

  logic w_spi_start, w_spi_idle, w_spi_done, w_spi_to;
  logic w_uart_start, w_uart_idle, w_uart_done, w_uart_to;
  logic [7:0] w_tx_byte;

  byte_req_hs #(
    .TIMEOUT (BUSY_TIMEOUT)
  ) u_spi_hs (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_spi_start),
    .i_busy    (spi_busy),
    .o_req     (spi_req),
    .o_idle    (w_spi_idle),
    .o_done    (w_spi_done),
    .o_timeout (w_spi_to)
  );

  byte_req_hs #(
    .TIMEOUT (BUSY_TIMEOUT)
  ) u_uart_hs (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_uart_start),
    .i_busy    (uart_busy),
    .o_req     (uart_req),
    .o_idle    (w_uart_idle),
    .o_done    (w_uart_done),
    .o_timeout (w_uart_to)
  );

  // Each axis goes out high byte first, so the byte index is swapped pairwise
  assign w_tx_byte = r_sample[8*(r_idx ^ 3'd1) +: 8];

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_spi_start  = 1'b0;
    w_uart_start = 1'b0;
    w_buf_next   = r_buf;
    unique case (r_state)
      StInitFmt: begin
        w_spi_start = w_spi_idle;
        if (w_spi_done) w_state_next = StInitPwr;
      end
      StInitPwr: begin
        w_spi_start = w_spi_idle;
        if (w_spi_done) w_state_next = StIdle;
      end
      StIdle: begin
        if (r_cnt == 32'(SAMPLE_PERIOD - 1)) w_state_next = StRead;
      end
      StRead: begin
        w_spi_start = w_spi_idle;
        if (w_spi_done) begin
          w_buf_next[8*r_idx +: 8] = spi_rdata;
          if (r_idx == 3'(NBYTES - 1)) begin
            w_idx_next   = '0;
            w_state_next = StPublish;
          end else begin
            w_idx_next = r_idx + 3'd1;
          end
        end
      end
      StPublish: w_state_next = StTxSep;
      StTxSep: begin
        w_uart_start = w_uart_idle;
        if (w_uart_done) w_state_next = StTxData;
      end
      StTxData: begin
        w_uart_start = w_uart_idle;
        if (w_uart_done) begin
          if (r_idx == 3'(NBYTES - 1)) begin
            w_idx_next = '0;
`ifdef ACCEL_STREAM_CHECKSUM_EN
            w_state_next = StTxCsum;
`else
            w_state_next = StIdle;
`endif
          end else begin
            w_idx_next = r_idx + 3'd1;
          end
        end
      end
`ifdef ACCEL_STREAM_CHECKSUM_EN
      StTxCsum: begin
        w_uart_start = w_uart_idle;
        if (w_uart_done) w_state_next = StIdle;
      end
`endif
      default: w_state_next = StInitFmt;
    endcase

    if (w_spi_to || w_uart_to) begin
      w_idx_next   = '0;
      w_state_next = (r_state == StInitFmt || r_state == StInitPwr) ? StInitFmt : StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StInitFmt;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_buf         <= '0;
      r_sample      <= '0;
      r_init_done   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_spi_rw      <= 1'b1;
      r_spi_addr    <= '0;
      r_spi_wdata   <= '0;
      r_uart_data   <= '0;
`ifdef ACCEL_STREAM_CHECKSUM_EN
      r_csum        <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_buf   <= w_buf_next;
      r_cnt   <= (r_state == StIdle && w_state_next == StIdle) ? r_cnt + 32'd1 : 32'd0;

      // Only a fully read sample is ever copied to the output register
      if (r_state == StRead && w_state_next == StPublish) r_sample <= w_buf_next;
      if (r_state == StInitPwr && w_spi_done) r_init_done <= 1'b1;
      if (w_spi_to || w_uart_to) r_timeout_err <= 1'b1;

      if (w_spi_start) begin
        if (r_state == StInitFmt) begin
          r_spi_rw    <= 1'b0;
          r_spi_addr  <= ADDR_DATA_FORMAT;
          r_spi_wdata <= INIT_DATA_FORMAT;
        end else if (r_state == StInitPwr) begin
          r_spi_rw    <= 1'b0;
          r_spi_addr  <= ADDR_POWER_CTL;
          r_spi_wdata <= INIT_POWER_CTL;
        end else begin
          r_spi_rw    <= 1'b1;
          r_spi_addr  <= ADDR_DATAX0 + {3'b000, r_idx};
          r_spi_wdata <= 8'h00;
        end
      end

      if (w_uart_start) begin
        if (r_state == StTxSep) begin
          r_uart_data <= UART_SEP;
        end else if (r_state == StTxData) begin
          r_uart_data <= w_tx_byte;
        end else begin
`ifdef ACCEL_STREAM_CHECKSUM_EN
          r_uart_data <= r_csum;
`else
          r_uart_data <= w_tx_byte;
`endif
        end
      end

`ifdef ACCEL_STREAM_CHECKSUM_EN
      if (r_state == StPublish) begin
        r_csum <= 8'h00;
      end else if (r_state == StTxData && w_uart_done) begin
        r_csum <= r_csum ^ r_uart_data;
      end
`endif
    end
  end

  assign spi_rw       = r_spi_rw;
  assign spi_addr     = r_spi_addr;
  assign spi_wdata    = r_spi_wdata;
  assign uart_data    = r_uart_data;
  assign sample_valid = (r_state == StPublish);
  assign sample_data  = r_sample;
  assign init_done    = r_init_done;
  assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_accel_stream_ctrl.sv
// Directed bench: a 3-axis instance (period 64) and a 1-axis instance (period 16)
// driven by simple SPI/UART busy models with transaction logs.
module tb_accel_stream_ctrl;

`ifdef ACCEL_STREAM_CHECKSUM_EN
  localparam int FLA = 8;
  localparam int FLB = 4;
`else
  localparam int FLA = 7;
  localparam int FLB = 3;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- instance A: 3 axes ----------------
  logic        a_rst, a_stall;
  logic        a_spi_req, a_spi_rw, a_spi_busy;
  logic [5:0]  a_spi_addr;
  logic [7:0]  a_spi_wdata, a_spi_rdata;
  logic        a_uart_req, a_uart_busy;
  logic [7:0]  a_uart_data;
  logic        a_sample_valid, a_init_done, a_timeout_err;
  logic [47:0] a_sample_data;

  accel_stream_ctrl #(
    .NUM_AXES      (3),
    .SAMPLE_PERIOD (64),
    .UART_SEP      (8'h0A),
    .BUSY_TIMEOUT  (1024)
  ) u_dut_a (
    .clk          (clk),
    .rst          (a_rst),
    .spi_req      (a_spi_req),
    .spi_rw       (a_spi_rw),
    .spi_addr     (a_spi_addr),
    .spi_wdata    (a_spi_wdata),
    .spi_busy     (a_spi_busy),
    .spi_rdata    (a_spi_rdata),
    .uart_req     (a_uart_req),
    .uart_data    (a_uart_data),
    .uart_busy    (a_uart_busy),
    .sample_valid (a_sample_valid),
    .sample_data  (a_sample_data),
    .init_done    (a_init_done),
    .timeout_err  (a_timeout_err)
  );

  // ---------------- instance B: 1 axis ----------------
  logic        b_rst;
  logic        b_spi_req, b_spi_rw, b_spi_busy;
  logic [5:0]  b_spi_addr;
  logic [7:0]  b_spi_wdata, b_spi_rdata;
  logic        b_uart_req, b_uart_busy;
  logic [7:0]  b_uart_data;
  logic        b_sample_valid, b_init_done, b_timeout_err;
  logic [15:0] b_sample_data;

  accel_stream_ctrl #(
    .NUM_AXES      (1),
    .SAMPLE_PERIOD (16),
    .UART_SEP      (8'h0A),
    .BUSY_TIMEOUT  (1024)
  ) u_dut_b (
    .clk          (clk),
    .rst          (b_rst),
    .spi_req      (b_spi_req),
    .spi_rw       (b_spi_rw),
    .spi_addr     (b_spi_addr),
    .spi_wdata    (b_spi_wdata),
    .spi_busy     (b_spi_busy),
    .spi_rdata    (b_spi_rdata),
    .uart_req     (b_uart_req),
    .uart_data    (b_uart_data),
    .uart_busy    (b_uart_busy),
    .sample_valid (b_sample_valid),
    .sample_data  (b_sample_data),
    .init_done    (b_init_done),
    .timeout_err  (b_timeout_err)
  );

  // ---------------- models and logs ----------------
  logic [13:0] a_wl [0:63];
  logic [5:0]  a_rl [0:63];
  logic [7:0]  a_ul [0:63];
  logic [7:0]  b_ul [0:63];
  int a_wn = 0, a_rn = 0, a_un = 0, b_un = 0;
  int a_sc = 0, a_uc = 0, b_sc = 0, b_uc = 0;

  // SPI model: busy for 4 cycles, read data = address - 0x31
  always @(posedge clk) begin
    if (a_rst) begin
      a_spi_busy <= 1'b0;
      a_sc       <= 0;
    end else if (a_sc != 0) begin
      a_sc <= a_sc - 1;
      if (a_sc == 1) a_spi_busy <= 1'b0;
    end else if (a_spi_req && !(a_stall && a_spi_addr == 6'h34)) begin
      a_spi_busy  <= 1'b1;
      a_sc        <= 4;
      a_spi_rdata <= {2'b00, a_spi_addr - 6'h31};
      if (a_spi_rw) begin
        if (a_rn < 64) a_rl[a_rn[5:0]] <= a_spi_addr;
        a_rn <= a_rn + 1;
      end else begin
        if (a_wn < 64) a_wl[a_wn[5:0]] <= {a_spi_addr, a_spi_wdata};
        a_wn <= a_wn + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (a_rst) begin
      a_uart_busy <= 1'b0;
      a_uc        <= 0;
    end else if (a_uc != 0) begin
      a_uc <= a_uc - 1;
      if (a_uc == 1) a_uart_busy <= 1'b0;
    end else if (a_uart_req) begin
      a_uart_busy <= 1'b1;
      a_uc        <= 3;
      if (a_un < 64) a_ul[a_un[5:0]] <= a_uart_data;
      a_un <= a_un + 1;
    end
  end

  always @(posedge clk) begin
    if (b_rst) begin
      b_spi_busy <= 1'b0;
      b_sc       <= 0;
    end else if (b_sc != 0) begin
      b_sc <= b_sc - 1;
      if (b_sc == 1) b_spi_busy <= 1'b0;
    end else if (b_spi_req) begin
      b_spi_busy  <= 1'b1;
      b_sc        <= 4;
      b_spi_rdata <= {2'b00, b_spi_addr - 6'h31};
    end
  end

  always @(posedge clk) begin
    if (b_rst) begin
      b_uart_busy <= 1'b0;
      b_uc        <= 0;
    end else if (b_uc != 0) begin
      b_uc <= b_uc - 1;
      if (b_uc == 1) b_uart_busy <= 1'b0;
    end else if (b_uart_req) begin
      b_uart_busy <= 1'b1;
      b_uc        <= 3;
      if (b_un < 64) b_ul[b_un[5:0]] <= b_uart_data;
      b_un <= b_un + 1;
    end
  end

  // ---------------- monitors (sampled on the falling edge) ----------------
  int          a_cyc = 0, a_svn = 0, a_r34 = 0, a_toc = 0;
  logic        a_sv_prev = 1'b0, a_sv_long = 1'b0, a_sr_prev = 1'b0, a_to_prev = 1'b0;
  logic        a_both = 1'b0, b_both = 1'b0;
  logic [47:0] a_sv_data = '0;
  int          b_cyc = 0, b_svn = 0, b_uf_cyc = 0, b_dn = 0;
  logic        b_ub_prev = 1'b0, b_sr_prev = 1'b0, b_uf_seen = 1'b0;
  logic [15:0] b_sv_data = '0;
  int          b_dw [0:7];

  always @(negedge clk) begin
    a_cyc     <= a_cyc + 1;
    a_sv_prev <= a_sample_valid;
    a_sr_prev <= a_spi_req;
    a_to_prev <= a_timeout_err;
    if (a_sample_valid) begin
      a_svn     <= a_svn + 1;
      a_sv_data <= a_sample_data;
      if (a_sv_prev) a_sv_long <= 1'b1;
    end
    if (!a_sr_prev && a_spi_req && a_spi_addr == 6'h34) a_r34 <= a_cyc;
    if (!a_to_prev && a_timeout_err) a_toc <= a_cyc;
    if (a_spi_req && a_uart_req) a_both <= 1'b1;
  end

  always @(negedge clk) begin
    b_cyc     <= b_cyc + 1;
    b_ub_prev <= b_uart_busy;
    b_sr_prev <= b_spi_req;
    if (b_sample_valid) begin
      b_svn     <= b_svn + 1;
      b_sv_data <= b_sample_data;
    end
    if (b_ub_prev && !b_uart_busy) begin
      b_uf_cyc  <= b_cyc;
      b_uf_seen <= 1'b1;
    end
    if (!b_sr_prev && b_spi_req && b_uf_seen) begin
      b_dw[b_dn[2:0]] <= b_cyc - b_uf_cyc;
      b_dn            <= b_dn + 1;
      b_uf_seen       <= 1'b0;
    end
    if (b_spi_req && b_uart_req) b_both <= 1'b1;
  end

  logic [7:0] exp_a [0:7];
  logic [7:0] exp_b [0:3];

  // ---------------- tests ----------------
  task automatic test_reset();
    a_rst   = 1'b1;
    b_rst   = 1'b1;
    a_stall = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({a_spi_req, a_uart_req} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_req: got %b want 00", {a_spi_req, a_uart_req});
    end
    n_cmp++;
    if (a_spi_rw !== 1'b1) begin
      n_err++;
      $display("FAIL reset_spi_rw: got %b want 1", a_spi_rw);
    end
    n_cmp++;
    if ({a_spi_addr, a_spi_wdata, a_uart_data} !== 22'h0) begin
      n_err++;
      $display("FAIL reset_addr_data: got %h want 0", {a_spi_addr, a_spi_wdata, a_uart_data});
    end
    n_cmp++;
    if ({a_sample_valid, a_sample_data} !== 49'h0) begin
      n_err++;
      $display("FAIL reset_sample: got %h want 0", {a_sample_valid, a_sample_data});
    end
    n_cmp++;
    if ({a_init_done, a_timeout_err} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 00", {a_init_done, a_timeout_err});
    end
  endtask

  task automatic test_init();
    int wb;
    wb    = a_wn;
    a_rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (a_init_done !== 1'b0) begin
      n_err++;
      $display("FAIL init_done_early: got %b want 0", a_init_done);
    end
    for (int i = 0; i < 300; i++) begin
      if (a_init_done) break;
      @(negedge clk);
    end
    n_cmp++;
    if (a_init_done !== 1'b1) begin
      n_err++;
      $display("FAIL init_done: got %b want 1 (timed out)", a_init_done);
    end
    n_cmp++;
    if (a_wn - wb !== 2) begin
      n_err++;
      $display("FAIL init_write_count: got %0d want 2", a_wn - wb);
    end
    n_cmp++;
    if (a_wl[6'(wb)] !== {6'h31, 8'h01}) begin
      n_err++;
      $display("FAIL init_write0: got %h want %h", a_wl[6'(wb)], {6'h31, 8'h01});
    end
    n_cmp++;
    if (a_wl[6'(wb + 1)] !== {6'h2D, 8'h08}) begin
      n_err++;
      $display("FAIL init_write1: got %h want %h", a_wl[6'(wb + 1)], {6'h2D, 8'h08});
    end
  endtask

  task automatic test_frame();
    int ub, sb, rb;
    ub = a_un;
    sb = a_svn;
    rb = a_rn;
    for (int i = 0; i < 1500; i++) begin
      if (a_un >= ub + FLA) break;
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
    n_cmp++;
    if (a_un - ub !== FLA) begin
      n_err++;
      $display("FAIL frame_len: got %0d want %0d", a_un - ub, FLA);
    end
    for (int k = 0; k < FLA; k++) begin
      n_cmp++;
      if (a_ul[6'(ub + k)] !== exp_a[k]) begin
        n_err++;
        $display("FAIL frame_byte%0d: got %h want %h", k, a_ul[6'(ub + k)], exp_a[k]);
      end
    end
    n_cmp++;
    if (a_rn - rb !== 6) begin
      n_err++;
      $display("FAIL read_count: got %0d want 6", a_rn - rb);
    end
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (a_rl[6'(rb + k)] !== 6'(6'h32 + k)) begin
        n_err++;
        $display("FAIL read_addr%0d: got %h want %h", k, a_rl[6'(rb + k)], 6'(6'h32 + k));
      end
    end
    n_cmp++;
    if (a_svn - sb !== 1 || a_sv_long !== 1'b0) begin
      n_err++;
      $display("FAIL sample_valid: got %0d pulses long=%b want 1 pulse long=0",
               a_svn - sb, a_sv_long);
    end
    n_cmp++;
    if (a_sv_data !== 48'h0605_0403_0201) begin
      n_err++;
      $display("FAIL sample_data: got %h want 060504030201", a_sv_data);
    end
  endtask

  task automatic test_timeout();
    int ub, sb;
    logic req_at_to;
    ub      = a_un;
    sb      = a_svn;
    a_stall = 1'b1;
    req_at_to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (a_timeout_err) break;
      @(negedge clk);
    end
    req_at_to = a_spi_req;
    @(negedge clk);
    n_cmp++;
    if (a_timeout_err !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_err: got %b want 1 (timed out)", a_timeout_err);
    end
    n_cmp++;
    if (req_at_to !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_req_drop: got %b want 0", req_at_to);
    end
    n_cmp++;
    if (a_toc - a_r34 !== 1024) begin
      n_err++;
      $display("FAIL timeout_latency: got %0d want 1024", a_toc - a_r34);
    end
    n_cmp++;
    if (a_svn !== sb || a_un !== ub) begin
      n_err++;
      $display("FAIL timeout_abort: got %0d samples %0d bytes want 0 0", a_svn - sb, a_un - ub);
    end
    a_stall = 1'b0;
    sb = a_svn;
    ub = a_un;
    for (int i = 0; i < 1500; i++) begin
      if (a_un >= ub + FLA) break;
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
    n_cmp++;
    if (a_svn - sb !== 1 || a_sv_data !== 48'h0605_0403_0201) begin
      n_err++;
      $display("FAIL recover_sample: got %0d pulses data %h want 1 060504030201",
               a_svn - sb, a_sv_data);
    end
    for (int k = 0; k < FLA; k++) begin
      n_cmp++;
      if (a_ul[6'(ub + k)] !== exp_a[k]) begin
        n_err++;
        $display("FAIL recover_byte%0d: got %h want %h", k, a_ul[6'(ub + k)], exp_a[k]);
      end
    end
    n_cmp++;
    if (a_timeout_err !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_sticky: got %b want 1", a_timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    int wb;
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (a_spi_req && a_spi_addr == 6'h33) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (seen !== 1'b1) begin
      n_err++;
      $display("FAIL mid_second_read: got %b want 1 (timed out)", seen);
    end
    a_rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({a_spi_req, a_init_done, a_timeout_err} !== 3'b000) begin
      n_err++;
      $display("FAIL mid_reset_state: got %b want 000", {a_spi_req, a_init_done, a_timeout_err});
    end
    wb    = a_wn;
    a_rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (a_wn > wb) break;
      @(negedge clk);
    end
    @(negedge clk);
    n_cmp++;
    if (a_wn <= wb || a_wl[6'(wb)] !== {6'h31, 8'h01}) begin
      n_err++;
      $display("FAIL mid_restart: got %0d writes first %h want %h", a_wn - wb, a_wl[6'(wb)],
               {6'h31, 8'h01});
    end
  endtask

  task automatic test_axes1();
    b_rst = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (b_un >= 2 * FLB && b_dn >= 1) break;
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
    n_cmp++;
    if (b_dn < 1 || b_dw[0] !== 18) begin
      n_err++;
      $display("FAIL axes1_dwell: got %0d want 18 (busy-fall to req-rise, 16 idle cycles)",
               b_dw[0]);
    end
    n_cmp++;
    if (b_svn !== 2 || b_sv_data !== 16'h0201) begin
      n_err++;
      $display("FAIL axes1_sample: got %0d pulses data %h want 2 0201", b_svn, b_sv_data);
    end
    for (int k = 0; k < 2 * FLB; k++) begin
      n_cmp++;
      if (b_ul[6'(k)] !== exp_b[k % FLB]) begin
        n_err++;
        $display("FAIL axes1_byte%0d: got %h want %h", k, b_ul[6'(k)], exp_b[k % FLB]);
      end
    end
  endtask

  task automatic test_onehot();
    n_cmp++;
    if ({a_both, b_both} !== 2'b00) begin
      n_err++;
      $display("FAIL req_exclusive: got %b want 00", {a_both, b_both});
    end
  endtask

  initial begin
    exp_a = '{8'h0A, 8'h02, 8'h01, 8'h04, 8'h03, 8'h06, 8'h05, 8'h07};
    exp_b = '{8'h0A, 8'h02, 8'h01, 8'h03};
    a_rst   = 1'b1;
    b_rst   = 1'b1;
    a_stall = 1'b0;
    test_reset();
    test_init();
    test_frame();
    test_timeout();
    test_reset_mid();
    test_axes1();
    test_onehot();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
